// File: rtl/matmul_tile_sequencer.sv
// Tile sequencer: walks M/N/K tiles of a large matmul over one core.
// Optional SEQ_PERF_CNT_EN adds a saturating busy-cycle counter.
module matmul_tile_sequencer #(
  parameter int MAT_MUL_SIZE      = 4,
  parameter int AWIDTH            = 11,
  parameter int ADDR_STRIDE_WIDTH = 8,
  parameter int TILE_CNT_WIDTH    = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start_reg,
  input  logic                         clear_done_reg,
  input  logic [AWIDTH-1:0]            address_mat_a,
  input  logic [AWIDTH-1:0]            address_mat_b,
  input  logic [AWIDTH-1:0]            address_mat_c,
  input  logic [ADDR_STRIDE_WIDTH-1:0] address_stride_a,
  input  logic [ADDR_STRIDE_WIDTH-1:0] address_stride_b,
  input  logic [ADDR_STRIDE_WIDTH-1:0] address_stride_c,
  input  logic [TILE_CNT_WIDTH-1:0]    num_tiles_m,
  input  logic [TILE_CNT_WIDTH-1:0]    num_tiles_n,
  input  logic [TILE_CNT_WIDTH-1:0]    num_tiles_k,
  input  logic [MAT_MUL_SIZE-1:0]      last_mask_m,
  input  logic [MAT_MUL_SIZE-1:0]      last_mask_k,
  input  logic [MAT_MUL_SIZE-1:0]      last_mask_n,
  output logic                         start_mat_mul,
  input  logic                         done_mat_mul,
  output logic [AWIDTH-1:0]            core_addr_a,
  output logic [AWIDTH-1:0]            core_addr_b,
  output logic [AWIDTH-1:0]            core_addr_c,
  output logic [MAT_MUL_SIZE-1:0]      core_mask_a_rows,
  output logic [MAT_MUL_SIZE-1:0]      core_mask_a_cols_b_rows,
  output logic [MAT_MUL_SIZE-1:0]      core_mask_b_cols,
  output logic                         accumulate,
  output logic                         busy,
  output logic                         done_reg,
  output logic                         config_err,
`ifdef SEQ_PERF_CNT_EN
  output logic [31:0]                  perf_cycles,
`endif
  output logic [3*TILE_CNT_WIDTH-1:0]  tiles_done
);

  localparam int TW  = TILE_CNT_WIDTH;
  localparam int MS  = MAT_MUL_SIZE;
  localparam int TDW = 3 * TILE_CNT_WIDTH;
  // tile edge is a power of two, so tile steps are shifts
  localparam int SH  = $clog2(MAT_MUL_SIZE);
  localparam logic [AWIDTH-1:0] MS_A = AWIDTH'(MS);

  typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

  state_t state, state_nx;

  logic [TW-1:0]     cnt_m, cnt_n, cnt_k;
  logic [TW-1:0]     idx_m, idx_n, idx_k;
  logic [MS-1:0]     lm_m, lm_n, lm_k;
  logic [AWIDTH-1:0] base_a, step_a, step_b, step_c;
  logic [AWIDTH-1:0] a_row, b_row, c_row;

  logic [TW-1:0]     k_nx, m_nx, n_nx;
  logic [AWIDTH-1:0] a_nx, b_nx, c_nx;
  logic [AWIDTH-1:0] a_row_nx, b_row_nx, c_row_nx;

  logic accept, cfg_bad, last_k, last_m, last_n, last_all, tile_ack;

  function automatic logic [MS-1:0] pick(
    input logic [TW-1:0] i,
    input logic [TW-1:0] c,
    input logic [MS-1:0] lm
  );
    return (i == c - TW'(1)) ? lm : '1;
  endfunction

  assign accept   = (state == IDLE) && start_reg;
  assign cfg_bad  = (num_tiles_m == '0) || (num_tiles_n == '0)
                 || (num_tiles_k == '0);
  assign last_k   = (idx_k == cnt_k - TW'(1));
  assign last_m   = (idx_m == cnt_m - TW'(1));
  assign last_n   = (idx_n == cnt_n - TW'(1));
  assign last_all = last_k && last_m && last_n;
  assign tile_ack = (state == RUN) && done_mat_mul;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start_reg) state_nx = cfg_bad ? DONE : RUN;
      RUN:  if (done_mat_mul) state_nx = last_all ? DONE : GAP;
      GAP:  state_nx = RUN;
      DONE: if (clear_done_reg) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    start_mat_mul = (state == RUN);
    busy          = (state == RUN) || (state == GAP);
    done_reg      = (state == DONE);
    accumulate    = (idx_k != '0);
  end

  // k innermost, then m, then n
  always_comb begin
    k_nx     = idx_k;
    m_nx     = idx_m;
    n_nx     = idx_n;
    a_nx     = core_addr_a;
    b_nx     = core_addr_b;
    c_nx     = core_addr_c;
    a_row_nx = a_row;
    b_row_nx = b_row;
    c_row_nx = c_row;
    unique case (1'b1)
      !last_k: begin
        k_nx = idx_k + TW'(1);
        a_nx = core_addr_a + step_a;
        b_nx = core_addr_b + step_b;
      end
      last_k && !last_m: begin
        k_nx     = '0;
        m_nx     = idx_m + TW'(1);
        a_row_nx = a_row + MS_A;
        a_nx     = a_row_nx;
        b_nx     = b_row;
        c_nx     = core_addr_c + MS_A;
      end
      last_k && last_m && !last_n: begin
        k_nx     = '0;
        m_nx     = '0;
        n_nx     = idx_n + TW'(1);
        a_row_nx = base_a;
        a_nx     = base_a;
        b_row_nx = b_row + MS_A;
        b_nx     = b_row_nx;
        c_row_nx = c_row + step_c;
        c_nx     = c_row_nx;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_m <= '0; cnt_n <= '0; cnt_k <= '0;
      idx_m <= '0; idx_n <= '0; idx_k <= '0;
      lm_m <= '0; lm_n <= '0; lm_k <= '0;
      base_a <= '0; step_a <= '0; step_b <= '0; step_c <= '0;
      a_row <= '0; b_row <= '0; c_row <= '0;
      core_addr_a <= '0; core_addr_b <= '0; core_addr_c <= '0;
      core_mask_a_rows <= '0;
      core_mask_a_cols_b_rows <= '0;
      core_mask_b_cols <= '0;
      config_err <= 1'b0;
      tiles_done <= '0;
    end else if (accept) begin
      cnt_m <= num_tiles_m;
      cnt_n <= num_tiles_n;
      cnt_k <= num_tiles_k;
      idx_m <= '0; idx_n <= '0; idx_k <= '0;
      lm_m <= last_mask_m;
      lm_n <= last_mask_n;
      lm_k <= last_mask_k;
      base_a <= address_mat_a;
      step_a <= AWIDTH'(address_stride_a) << SH;
      step_b <= AWIDTH'(address_stride_b) << SH;
      step_c <= AWIDTH'(address_stride_c) << SH;
      a_row <= address_mat_a;
      b_row <= address_mat_b;
      c_row <= address_mat_c;
      core_addr_a <= address_mat_a;
      core_addr_b <= address_mat_b;
      core_addr_c <= address_mat_c;
      core_mask_a_rows <= pick('0, num_tiles_m, last_mask_m);
      core_mask_a_cols_b_rows <= pick('0, num_tiles_k, last_mask_k);
      core_mask_b_cols <= pick('0, num_tiles_n, last_mask_n);
      config_err <= cfg_bad;
      tiles_done <= '0;
    end else if (tile_ack) begin
      tiles_done <= tiles_done + TDW'(1);
      if (!last_all) begin
        idx_k <= k_nx;
        idx_m <= m_nx;
        idx_n <= n_nx;
        a_row <= a_row_nx;
        b_row <= b_row_nx;
        c_row <= c_row_nx;
        core_addr_a <= a_nx;
        core_addr_b <= b_nx;
        core_addr_c <= c_nx;
        core_mask_a_rows <= pick(m_nx, cnt_m, lm_m);
        core_mask_a_cols_b_rows <= pick(k_nx, cnt_k, lm_k);
        core_mask_b_cols <= pick(n_nx, cnt_n, lm_n);
      end
    end
  end

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)                       perf_cycles <= '0;
    else if (accept)                 perf_cycles <= '0;
    else if (busy && perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// Bench for matmul_tile_sequencer: directed and random tile runs
// against a loop-nest reference model with an emulated core.
module tb_matmul_tile_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_reg, clear_done_reg;
  logic [10:0] address_mat_a, address_mat_b, address_mat_c;
  logic [7:0]  address_stride_a, address_stride_b, address_stride_c;
  logic [3:0]  num_tiles_m, num_tiles_n, num_tiles_k;
  logic [3:0]  last_mask_m, last_mask_k, last_mask_n;
  logic        start_mat_mul, done_mat_mul;
  logic [10:0] core_addr_a, core_addr_b, core_addr_c;
  logic [3:0]  core_mask_a_rows, core_mask_a_cols_b_rows, core_mask_b_cols;
  logic        accumulate, busy, done_reg, config_err;
  logic [11:0] tiles_done;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] perf_cycles;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  matmul_tile_sequencer dut (
    .clk(clk),
    .reset(reset),
    .start_reg(start_reg),
    .clear_done_reg(clear_done_reg),
    .address_mat_a(address_mat_a),
    .address_mat_b(address_mat_b),
    .address_mat_c(address_mat_c),
    .address_stride_a(address_stride_a),
    .address_stride_b(address_stride_b),
    .address_stride_c(address_stride_c),
    .num_tiles_m(num_tiles_m),
    .num_tiles_n(num_tiles_n),
    .num_tiles_k(num_tiles_k),
    .last_mask_m(last_mask_m),
    .last_mask_k(last_mask_k),
    .last_mask_n(last_mask_n),
    .start_mat_mul(start_mat_mul),
    .done_mat_mul(done_mat_mul),
    .core_addr_a(core_addr_a),
    .core_addr_b(core_addr_b),
    .core_addr_c(core_addr_c),
    .core_mask_a_rows(core_mask_a_rows),
    .core_mask_a_cols_b_rows(core_mask_a_cols_b_rows),
    .core_mask_b_cols(core_mask_b_cols),
    .accumulate(accumulate),
    .busy(busy),
    .done_reg(done_reg),
    .config_err(config_err),
`ifdef SEQ_PERF_CNT_EN
    .perf_cycles(perf_cycles),
`endif
    .tiles_done(tiles_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s", tag);
    end
  endtask

  task automatic set_cfg(input int nm, input int nn, input int nk,
                         input int ba, input int bb, input int bc,
                         input int sa, input int sb, input int sc,
                         input int lmm, input int lmk, input int lmn);
    num_tiles_m = 4'(nm); num_tiles_n = 4'(nn); num_tiles_k = 4'(nk);
    address_mat_a = 11'(ba);
    address_mat_b = 11'(bb);
    address_mat_c = 11'(bc);
    address_stride_a = 8'(sa);
    address_stride_b = 8'(sb);
    address_stride_c = 8'(sc);
    last_mask_m = 4'(lmm); last_mask_k = 4'(lmk); last_mask_n = 4'(lmn);
  endtask

  task automatic scramble_cfg();
    set_cfg($urandom_range(15, 0), $urandom_range(15, 0),
            $urandom_range(15, 0), $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
  endtask

  // Reference: loop nest n{m{k}}, plain arithmetic mod 2^11.
  task automatic run_seq(input int nm, input int nn, input int nk,
                         input int ba, input int bb, input int bc,
                         input int sa, input int sb, input int sc,
                         input int lmm, input int lmk, input int lmn,
                         input int dlo, input int dhi, input int rst_tile);
    int t, d, nt, busy_exp;
    nt = nm * nn * nk;
    busy_exp = nt - 1;
    t = 0;
    set_cfg(nm, nn, nk, ba, bb, bc, sa, sb, sc, lmm, lmk, lmn);
    start_reg = 1'b1;
    tick();
    start_reg = 1'b0;
    scramble_cfg();
    chk("accept_busy", busy, 1);
    chk("accept_cfgerr", config_err, 0);
    chk("accept_tiles", tiles_done, 0);
    for (int n = 0; n < nn; n++)
      for (int m = 0; m < nm; m++)
        for (int k = 0; k < nk; k++) begin
          if (t > 0) begin
            chk("gap_start_low", start_mat_mul, 0);
            done_mat_mul = 1'($urandom);
            tick();
            done_mat_mul = 1'b0;
          end
          chk("tile_start", start_mat_mul, 1);
          if (t == rst_tile) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            chk("rst_start", start_mat_mul, 0);
            chk("rst_busy", busy, 0);
            chk("rst_tiles", tiles_done, 0);
            tick();
            tick();
            chk("rst_quiet", start_mat_mul, 0);
            return;
          end
          chk("addr_a", core_addr_a, (ba + m*4 + k*4*sa) & 'h7ff);
          chk("addr_b", core_addr_b, (bb + n*4 + k*4*sb) & 'h7ff);
          chk("addr_c", core_addr_c, (bc + m*4 + n*4*sc) & 'h7ff);
          chk("mask_a_rows", core_mask_a_rows, (m == nm-1) ? lmm : 'hf);
          chk("mask_k", core_mask_a_cols_b_rows, (k == nk-1) ? lmk : 'hf);
          chk("mask_b_cols", core_mask_b_cols, (n == nn-1) ? lmn : 'hf);
          chk("accumulate", accumulate, (k != 0) ? 1 : 0);
          d = $urandom_range(dhi, dlo);
          busy_exp += d + 1;
          for (int j = 0; j < d; j++) begin
            start_reg = 1'($urandom);
            tick();
          end
          start_reg = 1'b0;
          chk("hold_start", start_mat_mul, 1);
          chk("hold_addr_a", core_addr_a, (ba + m*4 + k*4*sa) & 'h7ff);
          done_mat_mul = 1'b1;
          tick();
          done_mat_mul = 1'b0;
          t++;
          chk("tiles_done", tiles_done, t);
          chk("ack_start_low", start_mat_mul, 0);
          if (t == nt) begin
            chk("end_busy", busy, 0);
            chk("end_done", done_reg, 1);
`ifdef SEQ_PERF_CNT_EN
            chk("perf", perf_cycles, busy_exp);
`endif
          end else begin
            chk("mid_busy", busy, 1);
          end
        end
    tick();
    chk("done_sticky", done_reg, 1);
    clear_done_reg = 1'b1;
    tick();
    clear_done_reg = 1'b0;
    chk("cleared", done_reg, 0);
  endtask

  initial begin
    reset = 1'b1;
    start_reg = 1'b0;
    clear_done_reg = 1'b0;
    done_mat_mul = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    chk("rst_start", start_mat_mul, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done_reg, 0);
    chk("rst_cfgerr", config_err, 0);
    chk("rst_tiles", tiles_done, 0);
    chk("rst_addr_c", core_addr_c, 0);
    tick();

    run_seq(1, 1, 1, 0, 'h100, 'h200, 4, 4, 4, 'hf, 'hf, 'hf, 9, 9, -1);
    run_seq(2, 2, 2, 0, 0, 0, 8, 8, 8, 'hf, 'hf, 'hf, 0, 3, -1);
    run_seq(2, 1, 1, 0, 0, 0, 8, 8, 8, 'h3, 'hf, 'hf, 4, 4, -1);

    for (int r = 0; r < 6; r++)
      run_seq($urandom_range(3, 1), $urandom_range(3, 1),
              $urandom_range(3, 1), $urandom_range(2047, 0),
              $urandom_range(2047, 0), $urandom_range(2047, 0),
              $urandom_range(255, 0), $urandom_range(255, 0),
              $urandom_range(255, 0), $urandom_range(15, 0),
              $urandom_range(15, 0), $urandom_range(15, 0), 0, 4, -1);

    set_cfg(2, 2, 0, 0, 0, 0, 1, 1, 1, 'hf, 'hf, 'hf);
    start_reg = 1'b1;
    tick();
    start_reg = 1'b0;
    chk("cerr_flag", config_err, 1);
    chk("cerr_done", done_reg, 1);
    chk("cerr_start", start_mat_mul, 0);
    chk("cerr_busy", busy, 0);
    clear_done_reg = 1'b1;
    tick();
    clear_done_reg = 1'b0;
    chk("cerr_cleared", done_reg, 0);
    chk("cerr_kept", config_err, 1);

    set_cfg(0, 1, 1, 0, 0, 0, 1, 1, 1, 'hf, 'hf, 'hf);
    start_reg = 1'b1;
    tick();
    chk("cerr2_done", done_reg, 1);
    set_cfg(1, 1, 1, 0, 0, 0, 1, 1, 1, 'hf, 'hf, 'hf);
    clear_done_reg = 1'b1;
    tick();
    start_reg = 1'b0;
    clear_done_reg = 1'b0;
    chk("both_done", done_reg, 0);
    chk("both_busy", busy, 0);
    tick();
    chk("both_idle_busy", busy, 0);
    chk("both_idle_start", start_mat_mul, 0);
    run_seq(1, 2, 1, 'h7fc, 'h10, 'h7f0, 3, 5, 200, 'h7, 'h1, 'h3, 0, 2, -1);

    run_seq(2, 2, 1, 0, 0, 0, 4, 4, 4, 'hf, 'hf, 'hf, 1, 3, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
